// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and packing helpers for the 3x3 matrix multiplier front end.
package matmul_pkg;
    localparam int DATA_W    = 8;
    localparam int RES_W     = 16;
    localparam int N         = 3;
    localparam int NELEM     = N * N;
    localparam int NBEATS    = 2 * NELEM;
    localparam int IDX_W     = 5;
    localparam int A_BASE    = 0;
    localparam int B_BASE    = NELEM;
    localparam int LAST_ELEM = NELEM - 1;
    localparam int LAST_BEAT = NBEATS - 1;

    typedef enum logic [1:0] {LOAD, FIRE, DRAIN} seq_state_t;

    // Bit offset of element e inside a packed row-major operand bus.
    function automatic int elem_lsb(input int e);
        return e * DATA_W;
    endfunction
endpackage

// File: rtl/matmul_operand_loader.sv
// Indexed byte writes into the 18 operand registers (A at beats 0-8, B at beats 9-17).
module matmul_operand_loader
    import matmul_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [NELEM*DATA_W-1:0]   mul_a,
    output logic [NELEM*DATA_W-1:0]   mul_b
);
    genvar gi;
    generate
        for (gi = 0; gi < NBEATS; gi++) begin : g_elem
            logic [DATA_W-1:0] elem_q;
            logic [DATA_W-1:0] elem_d;

            always_comb begin
                elem_d = elem_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    elem_d = wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    elem_q <= '0;
                end else begin
                    elem_q <= elem_d;
                end
            end

            if (gi < B_BASE) begin : g_a
                assign mul_a[elem_lsb(gi - A_BASE) +: DATA_W] = elem_q;
            end else begin : g_b
                assign mul_b[elem_lsb(gi - B_BASE) +: DATA_W] = elem_q;
            end
        end
    endgenerate
endmodule

// File: rtl/matmul_sequencer.sv
// Load/fire/drain controller for the 3x3 multiplier. Optional job counter port
// is enabled by defining MATMUL_SEQ_PERF_EN.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      mul_en,
    output logic [NELEM*DATA_W-1:0]   mul_a,
    output logic [NELEM*DATA_W-1:0]   mul_b,
    input  logic [NELEM*RES_W-1:0]    mul_r,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RES_W-1:0]          out_data,
    output logic                      out_last,
    output logic                      busy
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [15:0]               job_count
`endif
);
    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_hs;
    logic             out_hs;
    logic [3:0]       res_sel;
    logic [RES_W-1:0] res_elem [NELEM];

    assign in_ready  = (state_q == LOAD);
    assign mul_en    = (state_q == FIRE);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != LOAD);
    assign out_last  = out_valid && (idx_q == IDX_W'(LAST_ELEM));
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    if (idx_q == IDX_W'(LAST_BEAT)) begin
                        state_d = FIRE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FIRE: begin
                state_d = DRAIN;
                idx_d   = '0;
            end
            DRAIN: begin
                if (out_hs) begin
                    if (idx_q == IDX_W'(LAST_ELEM)) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = '0;
            end
        endcase
        // abort overrides whatever handshake happened this cycle
        if (abort) begin
            state_d = LOAD;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    matmul_operand_loader u_loader (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_hs && !abort),
        .wr_idx  (idx_q),
        .wr_data (in_data),
        .mul_a   (mul_a),
        .mul_b   (mul_b)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NELEM; gi++) begin : g_res
            assign res_elem[gi] = mul_r[gi*RES_W +: RES_W];
        end
    endgenerate

    // idx runs past 8 while loading B; park the mux on R00 then
    assign res_sel  = (idx_q < IDX_W'(NELEM)) ? idx_q[3:0] : 4'd0;
    assign out_data = res_elem[res_sel];

`ifdef MATMUL_SEQ_PERF_EN
    logic [15:0] job_count_q, job_count_d;

    always_comb begin
        job_count_d = job_count_q;
        if (out_hs && out_last && !abort) begin
            job_count_d = job_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_count_q <= '0;
        end else begin
            job_count_q <= job_count_d;
        end
    end

    assign job_count = job_count_q;
`endif
endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer with a behavioural 3x3 datapath stand-in.
module tb_matmul_sequencer;
    typedef logic [7:0]  mat_t [9];
    typedef logic [15:0] res_t [9];
    typedef struct {
        mat_t a;
        mat_t b;
        res_t exp;
        bit   gaps;
        bit   bp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         mul_en;
    logic [71:0]  mul_a, mul_b;
    logic [143:0] mul_r = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic         out_last;
    logic         busy;
`ifdef MATMUL_SEQ_PERF_EN
    logic [15:0]  job_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int jobs_done = 0;
    logic [15:0] exp_q [$];
    vec_t vecs [4];

    matmul_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_r     (mul_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .job_count (job_count)
`endif
    );

    always #5 clk = ~clk;

    // Datapath stand-in: registered product captured on the mul_en edge
    always @(posedge clk) begin
        if (mul_en) begin
            en_cnt <= en_cnt + 1;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    logic [31:0] acc;
                    acc = 0;
                    for (int k = 0; k < 3; k++) begin
                        acc = acc + mul_a[(i*3+k)*8 +: 8] * mul_b[(k*3+j)*8 +: 8];
                    end
                    mul_r[(i*3+j)*16 +: 16] <= acc[15:0];
                end
            end
        end
    end

    function automatic res_t ref_mm(input mat_t a, input mat_t b);
        res_t r;
        for (int e = 0; e < 9; e++) begin
            int s;
            s = 0;
            for (int k = 0; k < 3; k++) begin
                s += int'(a[(e/3)*3 + k]) * int'(b[k*3 + (e%3)]);
            end
            r[e] = s[15:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input bit gaps);
        int w;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_job(input mat_t a, input mat_t b, input bit gaps);
        for (int i = 0; i < 18; i++) begin
            send_beat((i < 9) ? a[i] : b[i-9], gaps);
        end
    endtask

    task automatic drain_job(input int n, input bit bp);
        int got, cyc;
        logic [15:0] pd;
        logic pl;
        bit stalled;
        got = 0; cyc = 0; stalled = 0; pd = '0; pl = 1'b0;
        while (got < n && cyc < 200) begin
            out_ready = bp ? (cyc % 2 == 1) : 1'b1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("exp_queue_empty", 1, 0);
                    break;
                end
                if (stalled) begin
                    chk("stall_data", out_data, pd);
                    chk("stall_last", out_last, pl);
                end
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", out_last, (got == 8));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = out_data;
                    pl = out_last;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (got < n) chk("drain_timeout", got, n);
    endtask

    // Full job: load, check FIRE timing, drain with scoreboard, check idle afterwards
    task automatic run_job(input mat_t a, input mat_t b, input res_t exp, input bit gaps, input bit bp);
        int en0;
        foreach (exp[e]) exp_q.push_back(exp[e]);
        load_job(a, b, gaps);
        en0 = en_cnt;
        chk("fire_mul_en", mul_en, 1);
        chk("fire_out_valid", out_valid, 0);
        chk("fire_in_ready", in_ready, 0);
        chk("fire_busy", busy, 1);
        @(posedge clk); #1;
        chk("drain_mul_en", mul_en, 0);
        chk("drain_out_valid", out_valid, 1);
        chk("first_r00", out_data, exp[0]);
        drain_job(9, bp);
        chk("mul_en_pulses", en_cnt - en0, 1);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 1);
        jobs_done++;
        $display("job %0d done: R00=%0d R22=%0d", jobs_done, exp[0], exp[8]);
    endtask

    task automatic rand_mat(output mat_t m);
        for (int i = 0; i < 9; i++) m[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_mul_en"}, mul_en, 0);
        chk({tag, "_mul_a"}, (mul_a == '0), 1);
        chk({tag, "_mul_b"}, (mul_b == '0), 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_data"}, out_data, mul_r[15:0]);
    endtask

    initial begin
        mat_t a, b, a2;
        res_t r;
        logic [7:0] prev_b0;

        for (int i = 0; i < 9; i++) begin
            vecs[0].a[i]   = (i % 4 == 0) ? 8'd1 : 8'd0;
            vecs[0].b[i]   = 8'(i + 1);
            vecs[0].exp[i] = 16'(i + 1);
            vecs[1].a[i]   = 8'd255;
            vecs[1].b[i]   = 8'd255;
            vecs[1].exp[i] = 16'd64003;
        end
        vecs[0].gaps = 0; vecs[0].bp = 0;
        vecs[1].gaps = 0; vecs[1].bp = 0;
        for (int v = 2; v < 4; v++) begin
            rand_mat(vecs[v].a);
            rand_mat(vecs[v].b);
            vecs[v].exp  = ref_mm(vecs[v].a, vecs[v].b);
            vecs[v].gaps = 1;
            vecs[v].bp   = (v == 2);
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            run_job(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].gaps, vecs[v].bp);
        end

        // abort on the 10th beat: beat dropped, B00 keeps the previous job's value
        prev_b0 = vecs[3].b[0];
        rand_mat(a2);
        for (int i = 0; i < 9; i++) send_beat(a2[i], 0);
        in_valid = 1'b1;
        in_data  = ~prev_b0;
        abort    = 1'b1;
        chk("abort_in_ready_pre", in_ready, 1);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready_post", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_b00_kept", mul_b[7:0], prev_b0);
        chk("abort_a00_new", mul_a[7:0], a2[0]);
        $display("abort on beat 10 applied");
        rand_mat(a);
        rand_mat(b);
        run_job(a, b, ref_mm(a, b), 1, 0);

        // asynchronous reset in the middle of DRAIN at idx 4
        rand_mat(a);
        rand_mat(b);
        r = ref_mm(a, b);
        foreach (r[e]) exp_q.push_back(r[e]);
        load_job(a, b, 0);
        @(posedge clk); #1;
        drain_job(4, 0);
        chk("pre_reset_out_data", out_data, r[4]);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        $display("async reset during drain applied");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_mat(a);
        rand_mat(b);
        run_job(a, b, ref_mm(a, b), 1, 1);

`ifdef MATMUL_SEQ_PERF_EN
        // reset cleared the counter; one job completed since
        chk("job_count", job_count, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Front-end controller for the 3x3 matrix multiplier datapath. Accepts operand bytes over a valid/ready stream, assembles matrices A and B, issues a single-cycle multiply enable, then streams the nine 16-bit results out over a second valid/ready stream. Sits between the host-side byte interface and the multiplier, which it owns exclusively.

## Interface
- DATA_W, 8: operand element width
- RES_W, 16: result element width; must match the multiplier output width
- N, 3: matrix dimension, fixed at 3
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous clear to the initial LOAD state
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_data  in  DATA_W  operand byte; A00..A22 row-major, then B00..B22 row-major
- mul_en  out  1  multiply enable to the datapath
- mul_a  out  9*DATA_W  A elements, A00 in the LSBs, row-major
- mul_b  out  9*DATA_W  B elements, same packing
- mul_r  in  9*RES_W  datapath results, R00 in the LSBs, row-major
- out_valid  out  1  result beat valid
- out_ready  in  1  result beat consumed when out_valid & out_ready
- out_data  out  RES_W  result element, R00..R22 row-major
- out_last  out  1  high with R22
- busy  out  1  high in FIRE and DRAIN

## Operation
- States: LOAD, FIRE, DRAIN. Reset state is LOAD with idx=0.
- LOAD: in_ready=1. On each handshake, write in_data to element idx (0-8 A, 9-17 B) and increment idx. On the handshake at idx=17, go to FIRE.
- FIRE: mul_en=1 for exactly one cycle. in_ready=0. Next state is DRAIN with idx=0.
- DRAIN: out_valid=1. out_data=mul_r element idx. out_last=(idx==8). On a handshake, increment idx. On the handshake at idx=8, go to LOAD with idx=0.
- Wrap-around: the 5-bit idx never exceeds 17. Its reload is explicit; it does not roll over.
- Operand registers hold their values after FIRE. Partial reloads overwrite only the beats received.
- Result values pass through unmodified. Overflow handling is the datapath's job (modulo 2^16).
- abort: wins over any same-cycle handshake. The beat is dropped. Next state is LOAD with idx=0, mul_en=0, out_valid=0. Operand registers are not cleared.
- Simultaneous in and out handshakes cannot occur, because in_ready and out_valid are mutually exclusive.

## Timing
- Reset values: in_ready=1, mul_en=0, mul_a=0, mul_b=0, out_valid=0, out_data=mul_r[RES_W-1:0] (combinational mux, idx=0), out_last=0, busy=0.
- Reset mid-operation: returns to LOAD idx=0 immediately, asynchronously. Operands are cleared.
- All outputs except out_data are registered or decoded from state. out_data is a mux of mul_r by idx.
- Latency: handshake of the 18th beat at edge T. FIRE is the cycle after T. The datapath captures on edge T+1. out_valid=1 from T+1, with R00 valid in that cycle.
- Minimum job duration: 18 + 1 + 9 = 28 cycles with no backpressure.
- in_valid may drop between beats without penalty. out_ready=0 holds out_data and out_last stable.

## Configuration
- MATMUL_SEQ_PERF_EN defined: adds output port job_count [15:0].
  - Reset value 0.
  - Increments on the handshake where out_last=1.
  - Wraps from 65535 to 0.
  - Not cleared by abort.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package matmul_pkg:
  - DATA_W, RES_W, N constants
  - NELEM=9
  - Enum seq_state_t {LOAD, FIRE, DRAIN}
  - Packing helper constants: element offsets
- One sub-module, matmul_operand_loader: indexed write of 18 bytes into the A and B registers, with async reset. The FSM, index counter and output mux stay in matmul_sequencer.

## Test plan
- Identity A, B = 1..9 row-major, no backpressure: out R00..R22 = 1..9. out_last only on the 9th beat. R00 appears 1 cycle after the FIRE cycle.
- A = B = all 255: every result = 64003 (195075 mod 2^16). mul_en is high exactly 1 cycle.
- Random in_valid gaps and out_ready toggled every other cycle: results equal a reference model, and out_data is stable while stalled.
- abort asserted with in_valid on beat 10: beat dropped, in_ready stays 1, next 18 beats form a fresh job with correct results.
- rst_n low during DRAIN at idx=4: outputs go to reset values asynchronously. A following full job is correct.
- With MATMUL_SEQ_PERF_EN: three jobs plus one aborted job give job_count=3. Preloaded 65535 wraps to 0 after one job.
